rf_rename: RTL and testbench
============================

Name: rf_rename

Overview:
- Architectural register file with per-register rename tags. Sits between decoder and ROB.
- Downstream of the ROB commit port: writes committed values and clears tags.
- Upstream of the ROB operand lookup: returns each source's value if ready, else its producing ROB tag for the ROB's forwarding lookup.
- Records the destination tag of every issued instruction.

Parameters:
REG_NUM_WIDTH, 5, architectural register index width (32 regs)
ROB_SIZE_WIDTH, 5, ROB entry id width; tag is ROB_SIZE_WIDTH+1 bits, MSB=1 means "no dependency"
XLEN, 32, data width

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset; asynchronous and active-low
rdy_in  in  1  global stall; low = hold all state
flush_in  in  1  mispredict flush (ROB need_flush_out)
dec_valid  in  1  decoder issues one instruction this cycle
dec_rs1  in  REG_NUM_WIDTH  source 1 index
dec_rs2  in  REG_NUM_WIDTH  source 2 index
dec_rd  in  REG_NUM_WIDTH  destination index (0 = none)
dec_rob_id  in  ROB_SIZE_WIDTH  ROB id allocated to the issuing instruction
rob2rf_ready  in  1  commit strobe from ROB
rob_rd  in  REG_NUM_WIDTH  committed destination
rob_value  in  XLEN  committed value
rob_dependency  in  ROB_SIZE_WIDTH+1  tag of committing entry (MSB 0)
rs1_dep_out  out  ROB_SIZE_WIDTH+1  comb: rs1 tag (to ROB rf_dependency1)
rs2_dep_out  out  ROB_SIZE_WIDTH+1  comb: rs2 tag (to ROB rf_dependency2)
rs1_value_out  out  XLEN  comb: rs1 value, valid when rs1_dep_out MSB=1
rs2_value_out  out  XLEN  comb: rs2 value, valid when rs2_dep_out MSB=1

Behaviour:
- State: val[0..31] (XLEN), tag[0..31] (ROB_SIZE_WIDTH+1).
- Reset (rst_in low, async): all val=0; all tag={1'b1,0}. Outputs are combinational, so after reset each dep_out has MSB=1 and each value_out=0.
- rdy_in low: no state change. Combinational outputs still reflect state.
- Reads (combinational, from current state):
  - Register 0 always returns value 0 and tag MSB=1.
  - Otherwise returns val[rs] and tag[rs].
  - The same-cycle issue's own rd rename is not visible, so rs==rd reads the old mapping.
- Issue (posedge, dec_valid && rdy_in && !flush_in && dec_rd!=0): tag[dec_rd] <= {1'b0, dec_rob_id}.
- Commit (posedge, rob2rf_ready && rdy_in && rob_rd!=0):
  - val[rob_rd] <= rob_value.
  - tag[rob_rd] <= {1'b1,0} only if tag[rob_rd]==rob_dependency and no issue to the same rd this cycle.
  - Otherwise the tag is kept, since a younger producer owns the register.
- Commit + issue to the same rd in one cycle: the value is written and the tag takes the new dec_rob_id (issue wins).
- Flush (flush_in && rdy_in):
  - All tags <= {1'b1,0}; issue is ignored.
  - A commit arriving in the same cycle is still applied to val. Its tag clear is subsumed by the flush.
- Register 0 is never written and never renamed, under any combination of inputs.
- Commit is single-cycle with no handshake. The ROB never commits a tag it does not own.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: if rob2rf_ready && rob_rd==rs && rs!=0 && tag[rs]==rob_dependency, the read returns rob_value with tag MSB=1 in the same cycle, saving one ROB lookup cycle.
- Undefined: reads see registered state only. The stale tag still resolves correctly through the ROB lookup, because the committed ROB slot keeps its WRITE_RESULT state until it is reallocated.

Decomposition:
- Shared package/const file:
  - REG_NUM_WIDTH, ROB_SIZE_WIDTH, ROB_SIZE.
  - Tag constant TAG_NONE = {1'b1, ROB_SIZE_WIDTH'b0}.
  - Helper function tag_ready(tag) = tag[MSB].
- One natural sub-module: rf_read_port. It is the combinational read with the x0 and bypass mux and is instantiated twice, for rs1 and rs2.

Test Plan:
- Reset then read x5 -> rs1_value_out=0, rs1_dep_out MSB=1.
- Issue rd=3, rob_id=7; next cycle read x3 -> dep_out=0x07. Commit rd=3, dep=0x07, value=0xDEADBEEF -> next cycle x3 reads value 0xDEADBEEF, MSB=1.
- Issue rd=4 id=2, then issue rd=4 id=9, then commit rd=4 dep=2 value=0x11 -> val[4]=0x11, tag stays 0x09.
- Same cycle: commit rd=6 dep=1 value=0x55 and issue rd=6 id=4 -> tag[6]=0x04, val[6]=0x55.
- Issue rd=0 id=3 and commit rd=0 value=0xFF -> x0 reads 0 with MSB=1. Then flush with 3 pending tags -> all tags MSB=1 next cycle.
- With RF_COMMIT_BYPASS_EN: tag[8]=0x05, commit rd=8 dep=0x05 value=0x1234 while reading rs2=8 -> same cycle rs2_value_out=0x1234, MSB=1. Without the macro, the same cycle shows dep 0x05.

Source files
------------

// File: rtl/rf_rename_pkg.sv
// Shared widths, tag type and helpers for the rename register file.
package rf_rename_pkg;

    localparam int REG_NUM_WIDTH  = 5;
    localparam int ROB_SIZE_WIDTH = 5;
    localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;
    localparam int XLEN           = 32;
    localparam int REG_NUM        = 1 << REG_NUM_WIDTH;
    localparam int TAG_W          = ROB_SIZE_WIDTH + 1;

    typedef logic [TAG_W-1:0]         tag_t;
    typedef logic [REG_NUM_WIDTH-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]          data_t;

    // MSB set means the register holds its committed value; no producer pending.
    localparam tag_t TAG_NONE = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

    function automatic logic tag_ready(input tag_t tag);
        return tag[TAG_W-1];
    endfunction

endpackage

// File: rtl/rf_rename_if.sv
// Decoder issue, ROB commit and operand-lookup signals of the rename register file.
interface rf_rename_if;
    import rf_rename_pkg::*;

    logic     dec_valid;
    reg_idx_t dec_rs1;
    reg_idx_t dec_rs2;
    reg_idx_t dec_rd;
    logic [ROB_SIZE_WIDTH-1:0] dec_rob_id;

    logic     rob2rf_ready;
    reg_idx_t rob_rd;
    data_t    rob_value;
    tag_t     rob_dependency;

    tag_t     rs1_dep_out;
    tag_t     rs2_dep_out;
    data_t    rs1_value_out;
    data_t    rs2_value_out;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rob_id,
        output rob2rf_ready, rob_rd, rob_value, rob_dependency,
        input  rs1_dep_out, rs2_dep_out, rs1_value_out, rs2_value_out
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rob_id,
        input  rob2rf_ready, rob_rd, rob_value, rob_dependency,
        output rs1_dep_out, rs2_dep_out, rs1_value_out, rs2_value_out
    );

endinterface

// File: rtl/rf_read_port.sv
// Combinational operand read: x0 forcing and, with RF_COMMIT_BYPASS_EN, same-cycle commit bypass.
module rf_read_port
    import rf_rename_pkg::*;
(
    input  reg_idx_t rs,
    input  data_t    reg_val,
    input  tag_t     reg_tag,
`ifdef RF_COMMIT_BYPASS_EN
    input  logic     commit_valid,
    input  reg_idx_t commit_rd,
    input  data_t    commit_value,
    input  tag_t     commit_dep,
`endif
    output tag_t     dep,
    output data_t    value
);

    always_comb begin
        dep   = reg_tag;
        value = reg_val;
        if (rs == '0) begin
            dep   = TAG_NONE;
            value = '0;
        end
`ifdef RF_COMMIT_BYPASS_EN
        // Only the producer that still owns the register may forward its result.
        else if (commit_valid && commit_rd == rs && reg_tag == commit_dep) begin
            dep   = TAG_NONE;
            value = commit_value;
        end
`endif
    end

endmodule

// File: rtl/rf_rename.sv
// Architectural register file with per-register ROB rename tags.
// Optional commit-to-read bypass enabled by defining RF_COMMIT_BYPASS_EN.
module rf_rename
    import rf_rename_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    rf_rename_if.slave  bus
);

    data_t val_q [REG_NUM];
    tag_t  tag_q [REG_NUM];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= TAG_NONE;
            end
        end else if (rdy_in) begin
            // Entry 0 is skipped so x0 can never be written or renamed.
            for (int i = 1; i < REG_NUM; i++) begin
                if (bus.rob2rf_ready && bus.rob_rd == REG_NUM_WIDTH'(i))
                    val_q[i] <= bus.rob_value;

                if (flush_in)
                    tag_q[i] <= TAG_NONE;
                else if (bus.dec_valid && bus.dec_rd == REG_NUM_WIDTH'(i))
                    tag_q[i] <= {1'b0, bus.dec_rob_id};
                else if (bus.rob2rf_ready && bus.rob_rd == REG_NUM_WIDTH'(i)
                         && tag_q[i] == bus.rob_dependency)
                    tag_q[i] <= TAG_NONE;
            end
        end
    end

    rf_read_port u_rs1 (
        .rs           (bus.dec_rs1),
        .reg_val      (val_q[bus.dec_rs1]),
        .reg_tag      (tag_q[bus.dec_rs1]),
`ifdef RF_COMMIT_BYPASS_EN
        .commit_valid (bus.rob2rf_ready),
        .commit_rd    (bus.rob_rd),
        .commit_value (bus.rob_value),
        .commit_dep   (bus.rob_dependency),
`endif
        .dep          (bus.rs1_dep_out),
        .value        (bus.rs1_value_out)
    );

    rf_read_port u_rs2 (
        .rs           (bus.dec_rs2),
        .reg_val      (val_q[bus.dec_rs2]),
        .reg_tag      (tag_q[bus.dec_rs2]),
`ifdef RF_COMMIT_BYPASS_EN
        .commit_valid (bus.rob2rf_ready),
        .commit_rd    (bus.rob_rd),
        .commit_value (bus.rob_value),
        .commit_dep   (bus.rob_dependency),
`endif
        .dep          (bus.rs2_dep_out),
        .value        (bus.rs2_value_out)
    );

endmodule

// File: tb/tb_rf_rename.sv
// Randomized and directed bench for rf_rename against a register/owner reference model.
module tb_rf_rename;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_in;

    rf_rename_if bus ();

    rf_rename dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Model: committed value per register and the ROB id owning it (-1 = no producer).
    logic [31:0] m_val [32];
    int          m_own [32];

    function automatic logic [5:0] exp_dep(input logic [4:0] rs);
        if (rs == 5'd0 || m_own[rs] < 0) return 6'h20;
`ifdef RF_COMMIT_BYPASS_EN
        if (bus.rob2rf_ready && bus.rob_rd == rs && m_own[rs] == int'(bus.rob_dependency))
            return 6'h20;
`endif
        return 6'(m_own[rs]);
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
`ifdef RF_COMMIT_BYPASS_EN
        if (bus.rob2rf_ready && bus.rob_rd == rs && m_own[rs] >= 0
            && m_own[rs] == int'(bus.rob_dependency))
            return bus.rob_value;
`endif
        return m_val[rs];
    endfunction

    task automatic idle_inputs();
        rdy_in            = 1'b1;
        flush_in          = 1'b0;
        bus.dec_valid     = 1'b0;
        bus.dec_rd        = '0;
        bus.dec_rob_id    = '0;
        bus.rob2rf_ready  = 1'b0;
        bus.rob_rd        = '0;
        bus.rob_value     = '0;
        bus.rob_dependency = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_own[i] = -1;
        end
    endtask

    // Advance one clock, apply the architectural rules to the model, return at negedge with idle inputs.
    task automatic tick();
        int rd_c, rd_i;
        bit clear_ok;
        @(posedge clk_in);
        rd_c = int'(bus.rob_rd);
        rd_i = int'(bus.dec_rd);
        if (rdy_in) begin
            clear_ok = bus.rob2rf_ready && rd_c != 0 && m_own[rd_c] == int'(bus.rob_dependency);
            if (bus.rob2rf_ready && rd_c != 0) m_val[rd_c] = bus.rob_value;
            if (flush_in) begin
                for (int i = 0; i < 32; i++) m_own[i] = -1;
            end else begin
                if (clear_ok && !(bus.dec_valid && rd_i == rd_c)) m_own[rd_c] = -1;
                if (bus.dec_valid && rd_i != 0) m_own[rd_i] = int'(bus.dec_rob_id);
            end
        end
        @(negedge clk_in);
        idle_inputs();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] id);
        bus.dec_valid  = 1'b1;
        bus.dec_rd     = rd;
        bus.dec_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [5:0] dep, input logic [31:0] v);
        bus.rob2rf_ready   = 1'b1;
        bus.rob_rd         = rd;
        bus.rob_dependency = dep;
        bus.rob_value      = v;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle_inputs();
        model_reset();
        bus.dec_rs1 = 5'd5;
        bus.dec_rs2 = 5'd0;
        #12;
        checks++;
        if (bus.rs1_value_out !== 32'h0) begin
            errors++; $display("FAIL reset_rs1_value: got %h want %h", bus.rs1_value_out, 32'h0);
        end
        checks++;
        if (bus.rs1_dep_out[5] !== 1'b1) begin
            errors++; $display("FAIL reset_rs1_dep: got %h want MSB=1", bus.rs1_dep_out);
        end
        checks++;
        if (bus.rs2_dep_out !== 6'h20) begin
            errors++; $display("FAIL reset_rs2_dep: got %h want %h", bus.rs2_dep_out, 6'h20);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_issue_commit();
        issue(5'd3, 5'd7);
        tick();
        bus.dec_rs1 = 5'd3;
        #1;
        checks++;
        if (bus.rs1_dep_out !== 6'h07) begin
            errors++; $display("FAIL issue_tag: got %h want %h", bus.rs1_dep_out, 6'h07);
        end
        commit(5'd3, 6'h07, 32'hDEADBEEF);
        tick();
        #1;
        checks++;
        if (bus.rs1_value_out !== 32'hDEADBEEF || bus.rs1_dep_out !== 6'h20) begin
            errors++; $display("FAIL commit_clear: got %h/%h want %h/%h",
                               bus.rs1_value_out, bus.rs1_dep_out, 32'hDEADBEEF, 6'h20);
        end
    endtask

    task automatic test_younger_producer();
        issue(5'd4, 5'd2);
        tick();
        issue(5'd4, 5'd9);
        tick();
        commit(5'd4, 6'h02, 32'h11);
        tick();
        bus.dec_rs1 = 5'd4;
        #1;
        checks++;
        if (bus.rs1_value_out !== 32'h11 || bus.rs1_dep_out !== 6'h09) begin
            errors++; $display("FAIL younger_keeps_tag: got %h/%h want %h/%h",
                               bus.rs1_value_out, bus.rs1_dep_out, 32'h11, 6'h09);
        end
    endtask

    task automatic test_same_cycle();
        commit(5'd6, 6'h01, 32'h55);
        issue(5'd6, 5'd4);
        tick();
        bus.dec_rs2 = 5'd6;
        #1;
        checks++;
        if (bus.rs2_value_out !== 32'h55 || bus.rs2_dep_out !== 6'h04) begin
            errors++; $display("FAIL commit_issue_same_rd: got %h/%h want %h/%h",
                               bus.rs2_value_out, bus.rs2_dep_out, 32'h55, 6'h04);
        end
        // Issue to the rd whose own tag is committing: issue must still win.
        commit(5'd6, 6'h04, 32'h66);
        issue(5'd6, 5'd12);
        tick();
        #1;
        checks++;
        if (bus.rs2_value_out !== 32'h66 || bus.rs2_dep_out !== 6'h0C) begin
            errors++; $display("FAIL issue_wins_clear: got %h/%h want %h/%h",
                               bus.rs2_value_out, bus.rs2_dep_out, 32'h66, 6'h0C);
        end
    endtask

    task automatic test_x0_flush();
        issue(5'd0, 5'd3);
        commit(5'd0, 6'h03, 32'hFF);
        tick();
        bus.dec_rs1 = 5'd0;
        #1;
        checks++;
        if (bus.rs1_value_out !== 32'h0 || bus.rs1_dep_out !== 6'h20) begin
            errors++; $display("FAIL x0_immutable: got %h/%h want %h/%h",
                               bus.rs1_value_out, bus.rs1_dep_out, 32'h0, 6'h20);
        end
        issue(5'd10, 5'd20); tick();
        issue(5'd11, 5'd21); tick();
        issue(5'd12, 5'd22); tick();
        bus.dec_rs2 = 5'd11;
        #1;
        checks++;
        if (bus.rs2_dep_out !== 6'h15) begin
            errors++; $display("FAIL pending_before_flush: got %h want %h", bus.rs2_dep_out, 6'h15);
        end
        flush_in = 1'b1;
        issue(5'd13, 5'd1);
        commit(5'd10, 6'h14, 32'h77);
        tick();
        for (int r = 0; r < 32; r++) begin
            bus.dec_rs1 = 5'(r);
            #1;
            checks++;
            if (bus.rs1_dep_out !== 6'h20 || bus.rs1_value_out !== exp_val(5'(r))) begin
                errors++; $display("FAIL flush_x%0d: got %h/%h want %h/%h", r,
                                   bus.rs1_dep_out, bus.rs1_value_out, 6'h20, exp_val(5'(r)));
            end
        end
        checks++;
        if (m_val[10] !== 32'h77) begin
            errors++; $display("FAIL flush_commit_model: got %h want %h", m_val[10], 32'h77);
        end
    endtask

    task automatic test_bypass();
        issue(5'd8, 5'd5);
        tick();
        commit(5'd8, 6'h05, 32'h1234);
        bus.dec_rs2 = 5'd8;
        #1;
        checks++;
`ifdef RF_COMMIT_BYPASS_EN
        if (bus.rs2_value_out !== 32'h1234 || bus.rs2_dep_out !== 6'h20) begin
            errors++; $display("FAIL bypass: got %h/%h want %h/%h",
                               bus.rs2_value_out, bus.rs2_dep_out, 32'h1234, 6'h20);
        end
`else
        if (bus.rs2_dep_out !== 6'h05) begin
            errors++; $display("FAIL no_bypass: got %h want %h", bus.rs2_dep_out, 6'h05);
        end
`endif
        tick();
        #1;
        checks++;
        if (bus.rs2_value_out !== 32'h1234 || bus.rs2_dep_out !== 6'h20) begin
            errors++; $display("FAIL after_bypass_commit: got %h/%h want %h/%h",
                               bus.rs2_value_out, bus.rs2_dep_out, 32'h1234, 6'h20);
        end
    endtask

    task automatic test_stall();
        issue(5'd15, 5'd3);
        commit(5'd3, 6'h20, 32'hAAAA5555);
        rdy_in = 1'b0;
        tick();
        flush_in = 1'b1;
        rdy_in = 1'b0;
        tick();
        bus.dec_rs1 = 5'd15;
        bus.dec_rs2 = 5'd3;
        #1;
        checks++;
        if (bus.rs1_dep_out !== 6'h20 || bus.rs2_value_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL stall_hold: got %h/%h want %h/%h",
                               bus.rs1_dep_out, bus.rs2_value_out, 6'h20, 32'hDEADBEEF);
        end
        issue(5'd15, 5'd3);
        rdy_in = 1'b0;
        tick();
        issue(5'd15, 5'd3);
        tick();
        #1;
        checks++;
        if (bus.rs1_dep_out !== 6'h03) begin
            errors++; $display("FAIL stall_release: got %h want %h", bus.rs1_dep_out, 6'h03);
        end
    endtask

    task automatic test_random();
        int rd;
        for (int n = 0; n < 400; n++) begin
            bus.dec_rs1 = 5'($urandom_range(0, 31));
            bus.dec_rs2 = ($urandom_range(0, 3) == 0) ? bus.dec_rs1 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 31)), 5'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                rd = (n % 3 == 0) ? int'(bus.dec_rs1) : $urandom_range(0, 31);
                if (m_own[rd] >= 0 && $urandom_range(0, 3) != 0)
                    commit(5'(rd), 6'(m_own[rd]), $urandom);
                else
                    commit(5'(rd), {1'b0, 5'($urandom)}, $urandom);
            end
            if ($urandom_range(0, 15) == 0) flush_in = 1'b1;
            if ($urandom_range(0, 7) == 0)  rdy_in = 1'b0;
            #1;
            checks++;
            if (bus.rs1_dep_out !== exp_dep(bus.dec_rs1) || bus.rs1_value_out !== exp_val(bus.dec_rs1)) begin
                errors++; $display("FAIL rand_rs1 n=%0d x%0d: got %h/%h want %h/%h", n, bus.dec_rs1,
                                   bus.rs1_dep_out, bus.rs1_value_out, exp_dep(bus.dec_rs1), exp_val(bus.dec_rs1));
            end
            checks++;
            if (bus.rs2_dep_out !== exp_dep(bus.dec_rs2) || bus.rs2_value_out !== exp_val(bus.dec_rs2)) begin
                errors++; $display("FAIL rand_rs2 n=%0d x%0d: got %h/%h want %h/%h", n, bus.dec_rs2,
                                   bus.rs2_dep_out, bus.rs2_value_out, exp_dep(bus.dec_rs2), exp_val(bus.dec_rs2));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        issue(5'd20, 5'd6);
        tick();
        #2;
        rst_in = 1'b0;
        model_reset();
        #1;
        bus.dec_rs1 = 5'd20;
        bus.dec_rs2 = 5'd3;
        #1;
        checks++;
        if (bus.rs1_dep_out !== 6'h20 || bus.rs2_value_out !== 32'h0) begin
            errors++; $display("FAIL async_reset: got %h/%h want %h/%h",
                               bus.rs1_dep_out, bus.rs2_value_out, 6'h20, 32'h0);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        bus.dec_rs1 = '0;
        bus.dec_rs2 = '0;
        test_reset();
        test_issue_commit();
        test_younger_producer();
        test_same_cycle();
        test_x0_flush();
        test_bypass();
        test_stall();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
